// File: rtl/collatz_pkg.sv
// Shared types for the Collatz-family kernels: FSM state encoding and
// the termination-cause code reported at the end of a run.
package collatz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_LOOP_A = 3'd2,
        ST_LOOP_B = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        EXIT_NORMAL = 2'd0,
        EXIT_OVF    = 2'd1,
        EXIT_TMO    = 2'd2
    } exit_cause_t;

endpackage

// File: rtl/collatz_step_dp.sv
// Combinational Collatz step: the next value of cur, plus the termination and
// overflow predicates that the control FSM evaluates in LOOP_A.
module collatz_step_dp #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt,
    output logic             is_le1,
    output logic             ovf,
    output logic             odd
);

    // 3*cur+1 needs two extra bits; any set carry bit means it did not fit.
    logic [WIDTH+1:0] triple;

    assign triple = {2'b00, cur} + {1'b0, cur, 1'b0} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign odd    = cur[0];
    assign is_le1 = (cur <= WIDTH'(1));
    assign ovf    = |triple[WIDTH+1:WIDTH];
    assign nxt    = odd ? triple[WIDTH-1:0] : (cur >> 1);

endmodule

// File: rtl/collatz_gen.sv
// Collatz step-count engine: start/finish handshake around a two-cycle-per-step
// iteration loop, with overflow and step-cap aborts reported via status flags.
module collatz_gen
    import collatz_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STEP_W    = 32,
    parameter int MAX_STEPS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  n,
    output logic              busy,
    output logic              finish,
    output logic [STEP_W-1:0] ret0,
    output logic              overflow,
    output logic              timeout
);

    // With no explicit cap, the run stops when the counter would saturate.
    localparam logic [STEP_W-1:0] STEP_CAP =
        (MAX_STEPS == 0) ? {STEP_W{1'b1}} : STEP_W'(MAX_STEPS);

    state_t            state_reg, state_next;
    exit_cause_t       cause_reg, cause_next;
    logic [WIDTH-1:0]  n_reg;
    logic [WIDTH-1:0]  cur_reg;
    logic [WIDTH-1:0]  nxt_reg;
    logic [STEP_W-1:0] step_reg;
    logic              load_nxt;

    logic [WIDTH-1:0]  dp_nxt;
    logic              dp_is_le1;
    logic              dp_ovf;
    logic              dp_odd;

    collatz_step_dp #(
        .WIDTH (WIDTH)
    ) u_step_dp (
        .cur    (cur_reg),
        .nxt    (dp_nxt),
        .is_le1 (dp_is_le1),
        .ovf    (dp_ovf),
        .odd    (dp_odd)
    );

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        load_nxt   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_INIT;
            end
            ST_INIT: begin
                state_next = ST_LOOP_A;
                cause_next = EXIT_NORMAL;
            end
            ST_LOOP_A: begin
                if (dp_is_le1) begin
                    state_next = ST_DONE;
                    cause_next = EXIT_NORMAL;
                end else if (step_reg == STEP_CAP) begin
                    state_next = ST_DONE;
                    cause_next = EXIT_TMO;
                end else if (dp_odd && dp_ovf) begin
                    state_next = ST_DONE;
                    cause_next = EXIT_OVF;
                end else begin
                    state_next = ST_LOOP_B;
                    load_nxt   = 1'b1;
                end
            end
            ST_LOOP_B: state_next = ST_LOOP_A;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cause_reg <= EXIT_NORMAL;
            n_reg     <= '0;
            cur_reg   <= '0;
            nxt_reg   <= '0;
            step_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            if (state_reg == ST_IDLE && start) n_reg <= n;
            if (state_reg == ST_INIT) begin
                cur_reg  <= n_reg;
                step_reg <= '0;
            end
            if (load_nxt) nxt_reg <= dp_nxt;
            if (state_reg == ST_LOOP_B) begin
                cur_reg  <= nxt_reg;
                step_reg <= step_reg + STEP_W'(1);
            end
        end
    end

    // step_reg is only rewritten in INIT/LOOP_B, so it doubles as the held result.
    assign busy     = (state_reg == ST_INIT) || (state_reg == ST_LOOP_A) ||
                      (state_reg == ST_LOOP_B);
    assign finish   = (state_reg == ST_DONE);
    assign ret0     = step_reg;
    assign overflow = (cause_reg == EXIT_OVF);
    assign timeout  = (cause_reg == EXIT_TMO);

endmodule

// File: doc/collatz_gen.md
# collatz_gen

Parametrised Collatz step-count engine: the next generation of the HLS-generated Collatz kernel. It accepts a start value `n` over a start/finish handshake and iterates `n -> n/2` (even) or `n -> 3n+1` (odd) until `n <= 1`. It returns the step count. Width is generic, and there are two new abort conditions: arithmetic overflow detection and a programmable step cap. It sits behind the kernel control wrapper like the existing generated kernels, with the same start/finish/ret0 contract plus status flags.

## Interface
Parameters:
- `WIDTH`, 32: width of `n` and of the internal current value.
- `STEP_W`, 32: width of the step counter and `ret0`.
- `MAX_STEPS`, 0: step cap. 0 means no cap; the counter saturation value applies instead.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request. Sampled only in IDLE.
- `n`  in  WIDTH  start value, captured on the accepted start.
- `busy`  out  1  high from the cycle after acceptance until finish.
- `finish`  out  1  one-cycle pulse; `ret0`/flags valid this cycle.
- `ret0`  out  STEP_W  steps executed.
- `overflow`  out  1  3n+1 exceeded 2^WIDTH-1; run aborted.
- `timeout`  out  1  step cap reached with cur > 1; run aborted.

## Operation
- States: IDLE, INIT, LOOP_A, LOOP_B, DONE.
- IDLE: `busy`=0. `start`=1 moves to INIT and captures `n`.
- INIT: `cur <= n`, `step <= 0`, clear `overflow`/`timeout`. Next state is LOOP_A.
- LOOP_A evaluates these conditions in priority order:
  - `cur <= 1`: go to DONE (normal exit).
  - Cap reached: go to DONE with `timeout`=1. The cap is reached when `step == MAX_STEPS` (MAX_STEPS != 0), or when `step` is all-ones (MAX_STEPS == 0).
  - `cur` odd and 3*cur+1 ≥ 2^WIDTH: go to DONE with `overflow`=1.
  - Otherwise, register the next value in `nxt` and go to LOOP_B.
  - 3*cur+1 is computed in WIDTH+2 bits. The low WIDTH bits are kept only when no overflow occurs.
- LOOP_B: `cur <= nxt`, `step <= step + 1`. Next state is LOOP_A. Initiation interval is 2 cycles per iteration.
- DONE:
  - `finish`=1 and `ret0 = step` for this one cycle.
  - Next state is IDLE.
  - `ret0`, `overflow` and `timeout` hold their values until the next INIT.
- `start` while busy, or in DONE, is ignored. It is not queued.
- `n` = 0 or 1 gives 0 steps with no flags set.
- Reset, including mid-run:
  - State returns to IDLE on the next edge.
  - `busy`, `finish`, `ret0`, `overflow` and `timeout` all go to 0.
  - Internal `cur`, `nxt` and `step` go to 0.
  - The in-flight run is discarded.

## Timing
- Start accepted in cycle 0 (IDLE, `start`=1). INIT is in cycle 1. LOOP_A is in cycles 2, 4, …; LOOP_B is in cycles 3, 5, ….
- A run of k completed steps pulses `finish` in cycle 2k+3.
- `busy` is high in cycles 1 … 2k+2 and low in the `finish` cycle.
- The earliest next accepted start is cycle 2k+4, which is the IDLE cycle after DONE.
- The flags are registered, so they are valid in the same cycle as `finish`.

## Structure
- `collatz_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_INIT`, `ST_LOOP_A`, `ST_LOOP_B`, `ST_DONE`);
  - the termination-cause encoding (`EXIT_NORMAL`, `EXIT_OVF`, `EXIT_TMO`), shared with other Collatz-family kernels.
- Sub-module `collatz_step_dp` is combinational. It takes `cur` and outputs `nxt`, `is_le1`, `ovf` and `odd`, all parameterised by WIDTH. The top-level `collatz_gen` holds the FSM, registers and handshake.

## Test plan
- `n`=6, defaults: `start` in cycle 0. Expect `finish` in cycle 19, `ret0`=8, `overflow`=0, `timeout`=0.
- `n`=1, then `n`=0: each gives `finish` in cycle 3, `ret0`=0, no flags.
- `n`=27, MAX_STEPS=10: `finish` in cycle 23, `ret0`=10, `timeout`=1. With MAX_STEPS=0: `ret0`=111, `finish` in cycle 225.
- WIDTH=8, `n`=255: `finish` in cycle 3, `ret0`=0, `overflow`=1. With `n`=85: 3·85+1=256 overflows, so `finish` in cycle 3 with `overflow`=1.
- `start` held high continuously with `n`=3 then `n`=6:
  - `n`=3 gives 7 steps, with `finish` in cycle 17.
  - The next accept is in cycle 18, with no acceptance while busy.
  - The second run's `finish` comes 19 cycles after its accept, with `ret0`=8.
- `rst_n` dropped in cycle 10 of an `n`=27 run: all outputs are 0 from the next cycle, `finish` is never pulsed, and a fresh `n`=6 run then completes normally.
